// File: rtl/alu_pkg.sv
// Shared types and default sizes for the ALU issue unit and its command FIFO.
package alu_pkg;

  localparam int ALU_WIDTH = 8;
  localparam int ALU_SEL_W = 4;
  localparam int ALU_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    HOLD  = 2'd2
  } alu_state_e;

endpackage

// File: rtl/alu_issue_fifo.sv
// Command FIFO: power-of-two depth, wrapping pointers, explicit occupancy counter.
module alu_issue_fifo #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         push,
  input  logic                         pop,
  input  logic [2*WIDTH+SEL_W-1:0]     wdata,
  output logic [2*WIDTH+SEL_W-1:0]     data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int ENTRY_W = 2 * WIDTH + SEL_W;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]   wptr_q, wptr_d;
  logic [PTR_W-1:0]   rptr_q, rptr_d;
  logic [PTR_W:0]     count_q, count_d;
  logic               do_push, do_pop;

  assign full    = (count_q == (PTR_W+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign data    = mem_q[rptr_q];
  // Clear wins over a same-cycle push or pop.
  assign do_push = push & ~full & ~clear;
  assign do_pop  = pop & ~empty & ~clear;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (clear) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (do_push) wptr_d = wptr_q + PTR_W'(1);
      if (do_pop)  rptr_d = rptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Issues queued commands to an external combinational ALU and returns
// registered results over a valid/ready channel, counting completions.
module alu_issue_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int SEL_W = ALU_SEL_W,
  parameter int DEPTH = ALU_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_a,
  input  logic [WIDTH-1:0]         in_b,
  input  logic [SEL_W-1:0]         in_sel,
  output logic [WIDTH-1:0]         alu_a,
  output logic [WIDTH-1:0]         alu_b,
  output logic [SEL_W-1:0]         alu_sel,
  input  logic [WIDTH-1:0]         alu_result,
  input  logic                     alu_carry,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_result,
  output logic                     out_carry,
  output logic                     out_zero,
  output logic [7:0]               op_count,
  output alu_state_e               dbg_state_o,
  output logic [$clog2(DEPTH):0]   dbg_count_o
);

  localparam int ENTRY_W = 2 * WIDTH + SEL_W;

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; a producer holds valid and its payload stable until then.

  alu_state_e         state_q, state_d;
  logic [WIDTH-1:0]   alu_a_q, alu_a_d;
  logic [WIDTH-1:0]   alu_b_q, alu_b_d;
  logic [SEL_W-1:0]   alu_sel_q, alu_sel_d;
  logic [WIDTH-1:0]   out_result_q, out_result_d;
  logic               out_carry_q, out_carry_d;
  logic               out_zero_q, out_zero_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         op_count_q, op_count_d;

  logic               fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [ENTRY_W-1:0] fifo_wdata, fifo_rdata;

  assign in_ready   = ~fifo_full;
  assign fifo_push  = in_valid;
  assign fifo_wdata = {in_a, in_b, in_sel};

  alu_issue_fifo #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .wdata (fifo_wdata),
    .data  (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (dbg_count_o)
  );

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_sel_d    = alu_sel_q;
    out_result_d = out_result_q;
    out_carry_d  = out_carry_q;
    out_zero_d   = out_zero_q;
    out_valid_d  = out_valid_q;
    op_count_d   = op_count_q;
    fifo_pop     = 1'b0;

    if (flush) begin
      // alu_* deliberately keep their last values across a flush.
      state_d     = IDLE;
      out_valid_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty) begin
            fifo_pop  = 1'b1;
            alu_a_d   = fifo_rdata[ENTRY_W-1 -: WIDTH];
            alu_b_d   = fifo_rdata[WIDTH+SEL_W-1 -: WIDTH];
            alu_sel_d = fifo_rdata[SEL_W-1:0];
            state_d   = DRIVE;
          end
        end
        DRIVE: begin
          out_result_d = alu_result;
          out_carry_d  = alu_carry;
          out_zero_d   = (alu_result == '0);
          out_valid_d  = 1'b1;
          state_d      = HOLD;
        end
        HOLD: begin
          if (out_ready) begin
            out_valid_d = 1'b0;
            op_count_d  = op_count_q + 8'd1;
            if (!fifo_empty) begin
              fifo_pop  = 1'b1;
              alu_a_d   = fifo_rdata[ENTRY_W-1 -: WIDTH];
              alu_b_d   = fifo_rdata[WIDTH+SEL_W-1 -: WIDTH];
              alu_sel_d = fifo_rdata[SEL_W-1:0];
              state_d   = DRIVE;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_sel_q    <= '0;
      out_result_q <= '0;
      out_carry_q  <= 1'b0;
      out_zero_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_sel_q    <= alu_sel_d;
      out_result_q <= out_result_d;
      out_carry_q  <= out_carry_d;
      out_zero_q   <= out_zero_d;
      out_valid_q  <= out_valid_d;
      op_count_q   <= op_count_d;
    end
  end

  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign alu_sel     = alu_sel_q;
  assign out_result  = out_result_q;
  assign out_carry   = out_carry_q;
  assign out_zero    = out_zero_q;
  assign out_valid   = out_valid_q;
  assign op_count    = op_count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with an adder standing in for the ALU.
module tb_alu_issue_unit;
  import alu_pkg::*;

  logic       clk, rst_n, flush;
  logic       in_valid, in_ready;
  logic [7:0] in_a, in_b;
  logic [3:0] in_sel;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_sel;
  logic       alu_carry;
  logic       out_valid, out_ready, out_carry, out_zero;
  logic [7:0] out_result, op_count;
  alu_state_e dbg_state;
  logic [2:0] dbg_count;

  alu_issue_unit dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_zero(out_zero), .op_count(op_count),
    .dbg_state_o(dbg_state), .dbg_count_o(dbg_count)
  );

  assign {alu_carry, alu_result} = {1'b0, alu_a} + {1'b0, alu_b};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] a, b;
    logic [3:0] sel;
    logic [7:0] res;
    logic       c, z;
  } vec_t;

  vec_t vecs[6];
  logic [9:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    return {(s[7:0] == 8'h00), s[8], s[7:0]};
  endfunction

  task automatic check_out(input string name, input logic [9:0] e);
    check({name, "_res"}, out_result, e[7:0]);
    check({name, "_c"}, out_carry, e[8]);
    check({name, "_z"}, out_zero, e[9]);
  endtask

  // Asserts reset from a settled point and checks the forced values at once.
  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    in_valid = 1'b1;
    #1;
    check({tag, "_state"}, dbg_state, IDLE);
    check({tag, "_cnt"}, dbg_count, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_out_result"}, out_result, 0);
    check({tag, "_out_carry"}, out_carry, 0);
    check({tag, "_out_zero"}, out_zero, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_sel"}, alu_sel, 0);
    check({tag, "_op_count"}, op_count, 0);
    @(negedge clk);
    check({tag, "_no_accept"}, dbg_count, 0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_vec(input vec_t v, inout logic [7:0] exp_cnt);
    in_a = v.a; in_b = v.b; in_sel = v.sel; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("vec_lat1_valid", out_valid, 0);
    @(negedge clk);
    check("vec_drive_state", dbg_state, DRIVE);
    check("vec_alu_a", alu_a, v.a);
    check("vec_alu_b", alu_b, v.b);
    check("vec_alu_sel", alu_sel, v.sel);
    check("vec_lat2_valid", out_valid, 0);
    @(negedge clk);
    check("vec_out_valid", out_valid, 1);
    check_out("vec", {v.z, v.c, v.res});
    @(negedge clk);
    exp_cnt = exp_cnt + 8'd1;
    check("vec_done_valid", out_valid, 0);
    check("vec_op_count", op_count, exp_cnt);
  endtask

  initial begin
    logic [7:0] cnt;
    logic [7:0] a, b, saved_cnt, saved_a;
    int got, guard, seen, last_cyc;

    vecs[0] = '{a: 8'h35, b: 8'hE1, sel: 4'h0, res: 8'h16, c: 1'b1, z: 1'b0};
    vecs[1] = '{a: 8'h80, b: 8'h80, sel: 4'h0, res: 8'h00, c: 1'b1, z: 1'b1};
    vecs[2] = '{a: 8'h00, b: 8'h00, sel: 4'hF, res: 8'h00, c: 1'b0, z: 1'b1};
    vecs[3] = '{a: 8'h7F, b: 8'h01, sel: 4'h9, res: 8'h80, c: 1'b0, z: 1'b0};
    vecs[4] = '{a: 8'hFF, b: 8'h01, sel: 4'h3, res: 8'h00, c: 1'b1, z: 1'b1};
    vecs[5] = '{a: 8'h12, b: 8'h34, sel: 4'h7, res: 8'h46, c: 1'b0, z: 1'b0};

    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_a = '0; in_b = '0; in_sel = '0;
    do_reset("rst0");

    cnt = 8'd0;
    foreach (vecs[i]) run_vec(vecs[i], cnt);

    // Backpressure: 1 held in HOLD + 4 queued, then in_ready drops.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a = 8'((i + 1) * 17);
      b = 8'(8'h23 + i * 49);
      in_a = a; in_b = b; in_sel = 4'(i); in_valid = 1'b1;
      exp_q.push_back(model(a, b));
      check("bp_in_ready", in_ready, 1);
      @(negedge clk);
    end
    in_a = 8'hAA; in_b = 8'h55;
    check("bp_full_ready", in_ready, 0);
    check("bp_full_cnt", dbg_count, 4);
    check("bp_hold_state", dbg_state, HOLD);
    check("bp_hold_valid", out_valid, 1);
    @(negedge clk);
    check("bp_still_cnt", dbg_count, 4);
    check("bp_stable_res", out_result, exp_q[0][7:0]);
    in_valid = 1'b0; out_ready = 1'b1;
    got = 0; guard = 0;
    while (got < 5 && guard < 40) begin
      if (out_valid) begin
        check_out("bp_order", exp_q.pop_front());
        got++;
      end
      @(negedge clk);
      guard++;
    end
    check("bp_drained", got, 5);
    exp_q.delete();

    // Throughput with out_ready high, from a fresh reset.
    do_reset("rst1");
    out_ready = 1'b1;
    got = 0; last_cyc = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (out_valid) begin
        if (exp_q.size() > 0) check_out("tp_order", exp_q.pop_front());
        else check("tp_extra", 1, 0);
        if (got > 0) check("tp_spacing", cyc - last_cyc, 2);
        last_cyc = cyc;
        got++;
      end
      if (cyc < 4) begin
        a = 8'(8'h40 + cyc * 8'h41);
        b = 8'(8'h0F * (cyc + 3));
        in_a = a; in_b = b; in_sel = 4'(cyc + 8); in_valid = 1'b1;
        exp_q.push_back(model(a, b));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("tp_results", got, 4);
    check("tp_op_count", op_count, 4);

    // Flush while in HOLD with 3 queued; a same-cycle push is discarded.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_a = 8'(8'h50 + i); in_b = 8'h01; in_sel = 4'h2; in_valid = 1'b1;
      @(negedge clk);
    end
    check("fl_pre_state", dbg_state, HOLD);
    check("fl_pre_cnt", dbg_count, 3);
    saved_cnt = op_count;
    saved_a = alu_a;
    check("fl_pre_alu_a", alu_a, 8'h50);
    in_a = 8'hC3; flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("fl_valid", out_valid, 0);
    check("fl_cnt", dbg_count, 0);
    check("fl_state", dbg_state, IDLE);
    check("fl_op_count", op_count, saved_cnt);
    check("fl_alu_hold", alu_a, saved_a);
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("fl_quiet_valid", out_valid, 0);
    check("fl_quiet_state", dbg_state, IDLE);

    // Reset in the middle of DRIVE.
    in_a = 8'h05; in_b = 8'h06; in_sel = 4'hA; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("mid_drive_state", dbg_state, DRIVE);
    do_reset("rst_mid");

    // op_count wrap: 255 completions, then one more.
    out_ready = 1'b1; in_valid = 1'b1;
    seen = 0; guard = 0;
    while (seen < 255 && guard < 2000) begin
      if (out_valid) seen++;
      in_a = 8'(guard); in_b = 8'h03; in_sel = 4'(guard);
      @(negedge clk);
      guard++;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    check("wrap_seen", seen, 255);
    check("wrap_255", op_count, 8'd255);
    guard = 0;
    while (!out_valid && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    check("wrap_next_valid", out_valid, 1);
    out_ready = 1'b1;
    @(negedge clk);
    check("wrap_0", op_count, 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_unit.md
ALU_ISSUE_UNIT -- requirements
Module: alu_issue_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, meaning operand and result width in bits.
REQ-002 The block SHALL have parameter SEL_W, default 4, meaning opcode (ALU select) width.
REQ-003 The block SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of two).
REQ-004 The block SHALL have port clk, input, 1 bit, meaning the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-006 The block SHALL have port flush, input, 1 bit, meaning synchronous discard of all queued and in-flight work.
REQ-007 The block SHALL have ports in_valid (input, 1), in_ready (output, 1), in_a (input, WIDTH), in_b (input, WIDTH) and in_sel (input, SEL_W), forming the command channel.
REQ-008 The block SHALL have ports alu_a (output, WIDTH), alu_b (output, WIDTH) and alu_sel (output, SEL_W), which drive the downstream combinational ALU A, B and sel.
REQ-009 The block SHALL have ports alu_result (input, WIDTH) and alu_carry (input, 1), which carry the ALU result and carry back.
REQ-010 The block SHALL have ports out_valid (output, 1), out_ready (input, 1), out_result (output, WIDTH), out_carry (output, 1) and out_zero (output, 1), forming the result channel.
REQ-011 The block SHALL have port op_count, output, 8 bits, meaning the number of completed result handshakes.

Function
REQ-012 A command SHALL be accepted only on a rising edge where in_valid and in_ready are both high; in_ready SHALL equal not-full of the FIFO.
REQ-013 The FIFO SHALL be first-in-first-out; a simultaneous push and pop SHALL leave occupancy unchanged; a push when full SHALL be impossible because in_ready is low.
REQ-014 The FSM SHALL have states IDLE, DRIVE and HOLD.
REQ-015 In IDLE with the FIFO non-empty, the FSM SHALL pop the head into registers alu_a/alu_b/alu_sel and go to DRIVE; otherwise it SHALL stay in IDLE.
REQ-016 DRIVE SHALL last exactly one cycle with alu_* stable; at its closing edge the block SHALL register out_result=alu_result, out_carry=alu_carry and out_zero=(alu_result==0), set out_valid, and go to HOLD.
REQ-017 In HOLD, out_valid and out_* SHALL be held stable until out_ready is high.
REQ-018 On the out_ready edge in HOLD, the block SHALL clear out_valid, increment op_count (wrapping 255->0), and pop the next command and enter DRIVE if the FIFO is non-empty, or else enter IDLE.
REQ-019 Latency SHALL be as follows: a command accepted into an empty, idle block produces out_valid high 2 cycles after the accepting edge.
REQ-020 Sustained throughput with out_ready held high SHALL be one result per 2 cycles.
REQ-021 alu_sel values SHALL pass through unmodified, including unused codes.
REQ-022 flush SHALL take priority over all other activity: it SHALL empty the FIFO, clear out_valid, and return to IDLE on the next edge; a push in the same cycle SHALL be discarded; op_count SHALL be unaffected; alu_* SHALL hold their values.

Reset
REQ-023 Assertion of rst_n low SHALL immediately force state IDLE, FIFO empty, in_ready=1, out_valid=0, out_result=0, out_carry=0, out_zero=0, alu_a=0, alu_b=0, alu_sel=0 and op_count=0, including in the middle of an operation.
REQ-024 Reset release SHALL be effective from the first rising edge after rst_n goes high; no command SHALL be accepted while rst_n is low.

Structure
REQ-025 A shared package alu_pkg SHALL hold the FSM state enum (IDLE/DRIVE/HOLD) and the WIDTH and SEL_W default constants.
REQ-026 The FIFO SHALL be one sub-module alu_issue_fifo (parameters WIDTH, SEL_W, DEPTH; ports push, pop, full, empty, data) with wrapping read/write pointers and an occupancy counter.

Verification (bench ALU stub: result = A+B, carry = bit 8 of the sum)
REQ-027 Single op: push a=8'h35, b=8'hE1, sel=0 into an idle block -> out_valid 2 cycles later with out_result=8'h16, out_carry=1 and out_zero=0.
REQ-028 Zero flag: push a=8'h80, b=8'h80 -> out_result=8'h00, out_carry=1, out_zero=1.
REQ-029 Backpressure: hold out_ready=0 and push 5 commands -> 4 are accepted into the FIFO plus 1 in HOLD, then in_ready=0; releasing out_ready returns all 5 in order.
REQ-030 Throughput: push 4 commands with out_ready=1 -> results appear every 2 cycles and op_count=4.
REQ-031 Flush: issue flush while in HOLD with 3 queued commands -> next cycle out_valid=0, FIFO empty, state IDLE, op_count unchanged.
REQ-032 Reset mid-op: drop rst_n during DRIVE -> all outputs return to their reset values immediately; 255 completions followed by one more -> op_count wraps to 0.
